// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding and mux select constants for the
// Fibonacci LED sequencer and its watchdog.
package fib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ADD   = 3'd2,
    ST_CHECK = 3'd3,
    ST_ON    = 3'd4,
    ST_OFF   = 3'd5,
    ST_SHIFT = 3'd6,
    ST_GAP   = 3'd7
  } state_t;

  localparam logic MUX_ADD = 1'b0;
  localparam logic MUX_DEC = 1'b1;

  // States that wait on a timer interrupt and are guarded by the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_ON) || (s == ST_OFF) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/fib_wdog.sv
// fib_wdog: cycle counter that flags when a wait state has lasted
// WDOG_LIMIT cycles. Cleared on every state entry, advanced only while
// the controller sits in a timer wait state.
module fib_wdog #(
  parameter int WDOG_WIDTH = 15,
  parameter int WDOG_LIMIT = 16000
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic clear,
  input  logic count,
  output logic expired
);

  // The count reaches LAST after WDOG_LIMIT-1 edges in the wait state, so
  // the abort edge is the WDOG_LIMIT-th edge after entry.
  localparam logic [WDOG_WIDTH-1:0] LAST = WDOG_WIDTH'(WDOG_LIMIT - 1);

  logic [WDOG_WIDTH-1:0] cnt_q;

  assign expired = count && (cnt_q == LAST);

  // Restart on state entry, otherwise count up while waiting and hold at the limit.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + WDOG_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// fib_sequencer: control FSM for the Fibonacci LED datapath.
// Computes successive Fibonacci terms and blinks the LED once per unit of
// each term, pacing with the on/off/gap timers. All outputs are registered
// and derived from the state being entered.
// Optional feature: define FIB_SEQ_ABORT_EN to add the abort_in port.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WDOG_WIDTH = 15,
  parameter int WDOG_LIMIT = 16000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       start_in,
  input  logic       zero_flag_in,
  input  logic       counter_zero_in,
  input  logic       t0_int_in,
  input  logic       t1_int_in,
  input  logic       t2_int_in,
  output logic       mux_sel_out,
  output logic       x1_set_out,
  output logic       x2_set_out,
  output logic       x3_set_out,
  output logic       x4_set_out,
  output logic       x5_set_out,
  output logic       reg_reset_out,
  output logic       t0_start_out,
  output logic       t1_start_out,
  output logic       t2_start_out,
  output logic       led_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out,
  output logic [2:0] state_out
`ifdef FIB_SEQ_ABORT_EN
  ,
  input  logic       abort_in
`endif
);

  state_t state_q, state_d;
  logic   entering;
  logic   wdog_expired;
  logic   abort_req;

  logic mux_sel_d, x1_set_d, x2_set_d, x3_set_d, x4_set_d, x5_set_d;
  logic reg_reset_d, t0_start_d, t1_start_d, t2_start_d;
  logic led_d, busy_d, done_d, error_d;

`ifdef FIB_SEQ_ABORT_EN
  assign abort_req = abort_in;
`else
  assign abort_req = 1'b0;
`endif

  assign entering = (state_d != state_q);

  fib_wdog #(
    .WDOG_WIDTH(WDOG_WIDTH),
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .clear   (entering),
    .count   (is_wait_state(state_q)),
    .expired (wdog_expired)
  );

  // Next state; interrupts beat the watchdog, and abort beats everything.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_in) state_d = ST_INIT;
      ST_INIT:  state_d = ST_ADD;
      ST_ADD:   state_d = ST_CHECK;
      ST_CHECK: state_d = zero_flag_in ? ST_SHIFT : ST_ON;
      ST_ON: begin
        if (t0_int_in) begin
          state_d = ST_OFF;
        end else if (wdog_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_OFF: begin
        if (t1_int_in) begin
          state_d = ST_CHECK;
        end else if (wdog_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_SHIFT: state_d = ST_GAP;
      ST_GAP: begin
        if (t2_int_in) begin
          if (counter_zero_in) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ADD;
          end
        end else if (wdog_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && abort_req) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  // Output values for the state being entered; start pulses only on entry.
  always_comb begin
    mux_sel_d   = MUX_ADD;
    x1_set_d    = 1'b0;
    x2_set_d    = 1'b0;
    x3_set_d    = 1'b0;
    x4_set_d    = 1'b0;
    x5_set_d    = 1'b0;
    reg_reset_d = 1'b0;
    t0_start_d  = 1'b0;
    t1_start_d  = 1'b0;
    t2_start_d  = 1'b0;
    led_d       = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_INIT: reg_reset_d = 1'b1;
      ST_ADD: begin
        x3_set_d  = 1'b1;
        x4_set_d  = 1'b1;
        mux_sel_d = MUX_ADD;
      end
      ST_ON: begin
        led_d      = 1'b1;
        t0_start_d = entering;
      end
      ST_OFF: begin
        if (entering) begin
          x4_set_d   = 1'b1;
          mux_sel_d  = MUX_DEC;
          t1_start_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        x1_set_d = 1'b1;
        x2_set_d = 1'b1;
        x5_set_d = 1'b1;
      end
      ST_GAP: t2_start_d = entering;
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q       <= ST_IDLE;
      mux_sel_out   <= 1'b0;
      x1_set_out    <= 1'b0;
      x2_set_out    <= 1'b0;
      x3_set_out    <= 1'b0;
      x4_set_out    <= 1'b0;
      x5_set_out    <= 1'b0;
      reg_reset_out <= 1'b0;
      t0_start_out  <= 1'b0;
      t1_start_out  <= 1'b0;
      t2_start_out  <= 1'b0;
      led_out       <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mux_sel_out   <= mux_sel_d;
      x1_set_out    <= x1_set_d;
      x2_set_out    <= x2_set_d;
      x3_set_out    <= x3_set_d;
      x4_set_out    <= x4_set_d;
      x5_set_out    <= x5_set_d;
      reg_reset_out <= reg_reset_d;
      t0_start_out  <= t0_start_d;
      t1_start_out  <= t1_start_d;
      t2_start_out  <= t2_start_d;
      led_out       <= led_d;
      busy_out      <= busy_d;
      done_out      <= done_d;
      error_out     <= error_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: drives fib_sequencer with a behavioural datapath and
// 3-cycle timer models. Each run pushes its expected summary into a
// scoreboard; a monitor gathers the run's activity and compares when busy falls.
module tb_fib_sequencer;
  import fib_pkg::*;

  localparam int LIMIT = 16;

  typedef struct {
    int done;
    int error;
    int led_rises;
    int x5_sets;
    int t0_starts;
    int reg_resets;
    int on_len;
  } exp_t;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  logic start_in = 1'b0;
  logic abort_in = 1'b0;
  logic zero_flag_in, counter_zero_in, t0_int_in, t1_int_in, t2_int_in;
  logic mux_sel_out, x1_set_out, x2_set_out, x3_set_out, x4_set_out, x5_set_out;
  logic reg_reset_out, t0_start_out, t1_start_out, t2_start_out;
  logic led_out, busy_out, done_out, error_out;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  int x5_init    = 5;
  bit force_zero = 1'b0;
  bit t0_en      = 1'b1;

  logic [7:0] x1, x2, x3, x4, x5;
  logic [1:0] t0_cnt, t1_cnt, t2_cnt;

  always #5 clock_in = ~clock_in;

  fib_sequencer #(.WDOG_WIDTH(15), .WDOG_LIMIT(LIMIT)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
    .zero_flag_in(zero_flag_in), .counter_zero_in(counter_zero_in),
    .t0_int_in(t0_int_in), .t1_int_in(t1_int_in), .t2_int_in(t2_int_in),
    .mux_sel_out(mux_sel_out), .x1_set_out(x1_set_out), .x2_set_out(x2_set_out),
    .x3_set_out(x3_set_out), .x4_set_out(x4_set_out), .x5_set_out(x5_set_out),
    .reg_reset_out(reg_reset_out), .t0_start_out(t0_start_out),
    .t1_start_out(t1_start_out), .t2_start_out(t2_start_out),
    .led_out(led_out), .busy_out(busy_out), .done_out(done_out),
    .error_out(error_out), .state_out(state_out)
`ifdef FIB_SEQ_ABORT_EN
    , .abort_in(abort_in)
`endif
  );

  // Datapath model: x1..x5 with reset values 0,1,0,0,x5_init.
  always @(posedge clock_in or negedge reset_in) begin
    if (!reset_in || reg_reset_out) begin
      x1 <= 8'd0; x2 <= 8'd1; x3 <= 8'd0; x4 <= 8'd0; x5 <= x5_init[7:0];
    end else begin
      if (x1_set_out) x1 <= x2;
      if (x2_set_out) x2 <= x3;
      if (x3_set_out) x3 <= x1 + x2;
      if (x4_set_out) x4 <= mux_sel_out ? x4 - 8'd1 : x1 + x2;
      if (x5_set_out) x5 <= x5 - 8'd1;
    end
  end

  assign zero_flag_in    = force_zero ? 1'b1 : (x4 == 8'd0);
  assign counter_zero_in = (x5 == 8'd0);

  // Timer models: interrupt fires three edges after the start pulse is sampled.
  always @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      t0_cnt <= 2'd0; t1_cnt <= 2'd0; t2_cnt <= 2'd0;
    end else begin
      t0_cnt <= t0_start_out ? 2'd3 : (t0_cnt != 2'd0 ? t0_cnt - 2'd1 : 2'd0);
      t1_cnt <= t1_start_out ? 2'd3 : (t1_cnt != 2'd0 ? t1_cnt - 2'd1 : 2'd0);
      t2_cnt <= t2_start_out ? 2'd3 : (t2_cnt != 2'd0 ? t2_cnt - 2'd1 : 2'd0);
    end
  end

  assign t0_int_in = t0_en && (t0_cnt == 2'd1);
  assign t1_int_in = (t1_cnt == 2'd1);
  assign t2_int_in = (t2_cnt == 2'd1);

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clock_in);
      if (state_out == st) return;
    end
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: state %0d not reached within %0d cycles", name, st, max);
  endtask

  task automatic wait_idle(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clock_in);
      if (!busy_out) return;
    end
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: busy still high after %0d cycles", name, max);
  endtask

  task automatic apply_stimulus(input string name, input int x5v, input bit fz, input bit t0e,
                                input bit gap_start, input bit off_abort, input exp_t e);
    x5_init    = x5v;
    force_zero = fz;
    t0_en      = t0e;
    sb_q.push_back(e);
    @(negedge clock_in);
    start_in = 1'b1;
    @(negedge clock_in);
    start_in = 1'b0;
    check_output({name, "_init_state"}, state_out, ST_INIT);
    check_output({name, "_init_reg_reset"}, reg_reset_out, 1);
    @(negedge clock_in);
    check_output({name, "_add_state"}, state_out, ST_ADD);
    check_output({name, "_reg_reset_one_cycle"}, reg_reset_out, 0);
    if (fz) begin
      wait_state(ST_CHECK, 50, {name, "_wait_check"});
      @(negedge clock_in);
      check_output({name, "_check_to_shift"}, state_out, ST_SHIFT);
    end
    if (gap_start) begin
      wait_state(ST_GAP, 500, {name, "_wait_gap"});
      start_in = 1'b1;
      @(negedge clock_in);
      start_in = 1'b0;
      check_output({name, "_start_ignored_state"}, state_out, ST_GAP);
      check_output({name, "_start_ignored_reset"}, reg_reset_out, 0);
    end
    if (off_abort) begin
      wait_state(ST_OFF, 50, {name, "_wait_off"});
      abort_in = 1'b1;
      @(negedge clock_in);
      abort_in = 1'b0;
      check_output({name, "_abort_state"}, state_out, ST_IDLE);
      check_output({name, "_abort_led"}, led_out, 0);
      check_output({name, "_abort_flags"}, {done_out, error_out}, 0);
    end
    wait_idle(3000, {name, "_wait_idle"});
    @(negedge clock_in);
    check_output({name, "_pulse_width"}, {done_out, error_out}, 0);
    repeat (3) @(negedge clock_in);
  endtask

  // Monitor: accumulate activity per run and compare against the scoreboard when busy falls.
  initial begin : monitor
    int m_led, m_x5, m_t0, m_rr, m_done, m_err, m_on;
    logic prev_busy, prev_led;
    logic [2:0] prev_state;
    exp_t e;
    m_led = 0; m_x5 = 0; m_t0 = 0; m_rr = 0; m_done = 0; m_err = 0; m_on = 0;
    prev_busy = 1'b0; prev_led = 1'b0; prev_state = 3'd0;
    forever begin
      @(negedge clock_in);
      if (!reset_in) begin
        prev_busy = 1'b0; prev_led = 1'b0; prev_state = 3'd0;
      end else begin
        if (busy_out && !prev_busy) begin
          m_led = 0; m_x5 = 0; m_t0 = 0; m_rr = 0; m_done = 0; m_err = 0; m_on = 0;
        end
        if (busy_out || prev_busy) begin
          if (led_out && !prev_led) m_led++;
          if (x5_set_out) m_x5++;
          if (t0_start_out) m_t0++;
          if (reg_reset_out) m_rr++;
          if (done_out) m_done++;
          if (error_out) m_err++;
          if (state_out == ST_ON) begin
            if (prev_state != ST_ON) m_on = 0;
            m_on++;
          end
        end
        if (!busy_out && prev_busy) begin
          if (sb_q.size() == 0) begin
            check_output("sb_unexpected_run_end", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_output("done_at_busy_fall", done_out, e.done);
            check_output("error_at_busy_fall", error_out, e.error);
            check_output("done_pulses", m_done, e.done);
            check_output("error_pulses", m_err, e.error);
            check_output("led_rises", m_led, e.led_rises);
            check_output("x5_set_pulses", m_x5, e.x5_sets);
            check_output("t0_start_pulses", m_t0, e.t0_starts);
            check_output("reg_reset_pulses", m_rr, e.reg_resets);
            check_output("last_on_cycles", m_on, e.on_len);
          end
        end
        prev_busy  = busy_out;
        prev_led   = led_out;
        prev_state = state_out;
      end
    end
  end

  initial begin : global_timeout
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    exp_t e;
    reset_in = 1'b0;
    repeat (3) @(negedge clock_in);
    check_output("reset_outputs",
                 {mux_sel_out, x1_set_out, x2_set_out, x3_set_out, x4_set_out, x5_set_out,
                  reg_reset_out, t0_start_out, t1_start_out, t2_start_out,
                  led_out, busy_out, done_out, error_out}, 0);
    check_output("reset_state", state_out, ST_IDLE);
    reset_in = 1'b1;
    repeat (5) @(negedge clock_in);
    check_output("idle_hold_state", state_out, ST_IDLE);
    check_output("idle_hold_busy", busy_out, 0);

    $display("[TB] full run, x5=5");
    e.done = 1; e.error = 0; e.led_rises = 19; e.x5_sets = 5;
    e.t0_starts = 19; e.reg_resets = 1; e.on_len = 4;
    apply_stimulus("full", 5, 1'b0, 1'b1, 1'b0, 1'b0, e);

    $display("[TB] zero term run");
    e.done = 1; e.error = 0; e.led_rises = 0; e.x5_sets = 1;
    e.t0_starts = 0; e.reg_resets = 1; e.on_len = 0;
    apply_stimulus("zero", 1, 1'b1, 1'b1, 1'b0, 1'b0, e);

    $display("[TB] watchdog run");
    e.done = 0; e.error = 1; e.led_rises = 1; e.x5_sets = 0;
    e.t0_starts = 1; e.reg_resets = 1; e.on_len = LIMIT;
    apply_stimulus("wdog", 5, 1'b0, 1'b0, 1'b0, 1'b0, e);

    $display("[TB] ignored start run");
    e.done = 1; e.error = 0; e.led_rises = 19; e.x5_sets = 5;
    e.t0_starts = 19; e.reg_resets = 1; e.on_len = 4;
    apply_stimulus("ignstart", 5, 1'b0, 1'b1, 1'b1, 1'b0, e);

`ifdef FIB_SEQ_ABORT_EN
    $display("[TB] abort run");
    e.done = 0; e.error = 0; e.led_rises = 1; e.x5_sets = 0;
    e.t0_starts = 1; e.reg_resets = 1; e.on_len = 4;
    apply_stimulus("abort", 5, 1'b0, 1'b1, 1'b0, 1'b1, e);
`endif

    repeat (5) @(negedge clock_in);
    check_output("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
